// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  // Header length field covers ADDR_W+1 bits so that a full 2^ADDR_W load is expressible
  localparam int HDR_W_DEF  = ADDR_W_DEF + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    CHK   = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_cksum.sv
// Wrapping-sum accumulator used to verify the trailing checksum word of a load.
// Only instantiated when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader_cksum #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] check_data,
  output logic              match
);

  logic [DATA_W-1:0] sum;

  // Accumulate header and data words; restart whenever a new load begins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + add_data;
    end
  end

  assign match = (sum == check_data);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: streams words from a valid/ready source into dmem
// and holds the processor in reset until the load completes.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN adds a trailing checksum word
// (wrapping sum of header and data) that must match before the CPU is released.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   n_q;
  logic              xfer;
  logic [ADDR_W:0]   hdr_n;
  logic [ADDR_W:0]   cnt_next;

  assign xfer     = in_valid & in_ready;
  assign hdr_n    = in_data[ADDR_W:0];
  assign cnt_next = words_loaded + 1'b1;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHK;

  logic ck_clear;
  logic ck_add;
  logic ck_match;

  assign ck_clear = (state == IDLE) && start;
  assign ck_add   = xfer && ((state == HDR) || (state == LOAD));

  prog_loader_cksum #(
    .DATA_W (DATA_W)
  ) u_cksum (
    .clock      (clock),
    .reset      (reset),
    .clear      (ck_clear),
    .add        (ck_add),
    .add_data   (in_data),
    .check_data (in_data),
    .match      (ck_match)
  );
`else
  localparam state_t AFTER_LOAD = RUN;
`endif

  // Loader FSM with registered handshake, dmem write bus and status outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      wren         <= 1'b0;
      address_dmem <= '0;
      data         <= '0;
      cpu_reset    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      base_q       <= '0;
      n_q          <= '0;
    end else begin
      // A write lasts exactly one cycle; only a LOAD transfer re-arms it
      wren <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            state    <= HDR;
            in_ready <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            n_q <= hdr_n;
            if (hdr_n > DEPTH_L) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else if (hdr_n == '0) begin
              state    <= AFTER_LOAD;
              in_ready <= (AFTER_LOAD == CHK);
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            // Address wraps modulo 2^ADDR_W by truncation
            address_dmem <= base_q + words_loaded[ADDR_W-1:0];
            data         <= in_data;
            wren         <= 1'b1;
            words_loaded <= cnt_next;
            if (cnt_next == n_q) begin
              state    <= AFTER_LOAD;
              in_ready <= (AFTER_LOAD == CHK);
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (ck_match) begin
              state <= RUN;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
`endif
        RUN: begin
          // Entered on the edge that launches the last write, so release lands one cycle after it
          cpu_reset <= 1'b0;
          done      <= 1'b1;
        end
        ERROR: begin
          error <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (default build and PROG_LOADER_CHECKSUM_EN build).
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [12:0] words_loaded;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  int          x_cyc[$];
  int          fall_cyc = -1;
  logic        prev_crst = 1'b1;

  prog_loader #(
    .ADDR_W (12),
    .DATA_W (32),
    .DEPTH  (4096)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  // Observe the DUT mid-cycle: dmem writes, accepted transfers, cpu_reset release
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (wren === 1'b1) begin
      w_addr.push_back(address_dmem);
      w_data.push_back(data);
      w_cyc.push_back(cyc);
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) x_cyc.push_back(cyc);
    if (prev_crst === 1'b1 && cpu_reset === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
    prev_crst = cpu_reset;
  end

  task automatic clear_log();
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    x_cyc.delete();
    fall_cyc = -1;
  endtask

  // Inputs change 1 time unit after a rising edge and take effect on the next one
  task automatic drive(input logic v, input logic [31:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [11:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%0h exp=0", wren); end
    total++; if (address_dmem !== 12'h000) begin bad++; $display("FAIL reset_addr got=%0h exp=0", address_dmem); end
    total++; if (data !== 32'h0) begin bad++; $display("FAIL reset_data got=%0h exp=0", data); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL reset_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0h exp=0", error); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0h exp=0", in_ready); end
    total++; if (words_loaded !== 13'd0) begin bad++; $display("FAIL reset_words got=%0d exp=0", words_loaded); end
    apply_reset();
    drive(1'b1, 32'h5);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%0h exp=0", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC;
    apply_reset();
    do_start(12'h010);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_hdr_ready got=%0h exp=1", in_ready); end
    drive(1'b1, 32'd3);
    drive(1'b1, 32'hA);
    drive(1'b1, 32'hB);
    drive(1'b1, 32'hC);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 3) begin bad++; $display("FAIL basic_nwrites got=%0d exp=3", w_addr.size()); end
    for (int i = 0; i < 3 && i < w_addr.size(); i++) begin
      total++; if (w_addr[i] !== 12'h010 + 12'(i)) begin bad++; $display("FAIL basic_addr%0d got=%0h exp=%0h", i, w_addr[i], 12'h010 + 12'(i)); end
      total++; if (w_data[i] !== exp_d[i]) begin bad++; $display("FAIL basic_data%0d got=%0h exp=%0h", i, w_data[i], exp_d[i]); end
      total++; if (w_cyc[i] != w_cyc[0] + i) begin bad++; $display("FAIL basic_consec%0d got=%0d exp=%0d", i, w_cyc[i], w_cyc[0] + i); end
    end
    if (w_cyc.size() == 3) begin
      total++; if (fall_cyc != w_cyc[2] + 1) begin bad++; $display("FAIL basic_release got=%0d exp=%0d", fall_cyc, w_cyc[2] + 1); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0h exp=1", done); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL basic_cpu_reset got=%0h exp=0", cpu_reset); end
    total++; if (words_loaded !== 13'd3) begin bad++; $display("FAIL basic_words got=%0d exp=3", words_loaded); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_run_ready got=%0h exp=0", in_ready); end
  endtask

  task automatic test_zero_header();
    apply_reset();
    do_start(12'h040);
    drive(1'b1, 32'd0);
    drive(1'b1, 32'h77);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 0) begin bad++; $display("FAIL zero_nwrites got=%0d exp=0", w_addr.size()); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL zero_cpu_reset got=%0h exp=0", cpu_reset); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%0h exp=1", done); end
    total++; if (words_loaded !== 13'd0) begin bad++; $display("FAIL zero_words got=%0d exp=0", words_loaded); end
  endtask

  task automatic test_stall();
    apply_reset();
    do_start(12'h100);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'h11);
    drive(1'b0, 32'hDEAD);
    drive(1'b0, 32'hBEEF);
    drive(1'b1, 32'h22);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 2) begin bad++; $display("FAIL stall_nwrites got=%0d exp=2", w_addr.size()); end
    total++; if (x_cyc.size() != 3) begin bad++; $display("FAIL stall_nxfer got=%0d exp=3", x_cyc.size()); end
    if (w_addr.size() == 2 && x_cyc.size() == 3) begin
      total++; if (w_addr[0] !== 12'h100 || w_data[0] !== 32'h11) begin bad++; $display("FAIL stall_w0 got=%0h/%0h exp=100/11", w_addr[0], w_data[0]); end
      total++; if (w_addr[1] !== 12'h101 || w_data[1] !== 32'h22) begin bad++; $display("FAIL stall_w1 got=%0h/%0h exp=101/22", w_addr[1], w_data[1]); end
      total++; if (w_cyc[0] != x_cyc[1] + 1) begin bad++; $display("FAIL stall_lat0 got=%0d exp=%0d", w_cyc[0], x_cyc[1] + 1); end
      total++; if (w_cyc[1] != x_cyc[2] + 1) begin bad++; $display("FAIL stall_lat1 got=%0d exp=%0d", w_cyc[1], x_cyc[2] + 1); end
      total++; if (w_cyc[1] - w_cyc[0] != 3) begin bad++; $display("FAIL stall_gap got=%0d exp=3", w_cyc[1] - w_cyc[0]); end
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done got=%0h exp=1", done); end
  endtask

  task automatic test_wrap();
    apply_reset();
    do_start(12'hFFF);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'h1234);
    drive(1'b1, 32'h5678);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 2) begin bad++; $display("FAIL wrap_nwrites got=%0d exp=2", w_addr.size()); end
    if (w_addr.size() == 2) begin
      total++; if (w_addr[0] !== 12'hFFF) begin bad++; $display("FAIL wrap_addr0 got=%0h exp=fff", w_addr[0]); end
      total++; if (w_addr[1] !== 12'h000) begin bad++; $display("FAIL wrap_addr1 got=%0h exp=0", w_addr[1]); end
    end
    total++; if (words_loaded !== 13'd2) begin bad++; $display("FAIL wrap_words got=%0d exp=2", words_loaded); end
  endtask

  task automatic test_error();
    apply_reset();
    do_start(12'h000);
    drive(1'b1, 32'd4097);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (error !== 1'b1) begin bad++; $display("FAIL err_error got=%0h exp=1", error); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL err_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL err_done got=%0h exp=0", done); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_in_ready got=%0h exp=0", in_ready); end
    do_start(12'h200);
    drive(1'b1, 32'd1);
    drive(1'b1, 32'h99);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 0) begin bad++; $display("FAIL err_nwrites got=%0d exp=0", w_addr.size()); end
    total++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0h/%0h exp=1/1", error, cpu_reset); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL err_restart_ready got=%0h exp=0", in_ready); end
  endtask

  task automatic test_midload_reset();
    apply_reset();
    do_start(12'h020);
    drive(1'b1, 32'd3);
    drive(1'b1, 32'hA1);
    total++; if (wren !== 1'b1) begin bad++; $display("FAIL mid_pre_wren got=%0h exp=1", wren); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL mid_wren got=%0h exp=0", wren); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_cpu_reset got=%0h exp=1", cpu_reset); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%0h exp=0", in_ready); end
    total++; if (words_loaded !== 13'd0) begin bad++; $display("FAIL mid_words got=%0d exp=0", words_loaded); end
    apply_reset();
    do_start(12'h030);
    drive(1'b1, 32'd3);
    drive(1'b1, 32'h1);
    drive(1'b1, 32'h2);
    drive(1'b1, 32'h3);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (w_addr.size() != 3) begin bad++; $display("FAIL mid_nwrites got=%0d exp=3", w_addr.size()); end
    if (w_addr.size() == 3) begin
      total++; if (w_addr[2] !== 12'h032 || w_data[2] !== 32'h3) begin bad++; $display("FAIL mid_last got=%0h/%0h exp=32/3", w_addr[2], w_data[2]); end
    end
    total++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin bad++; $display("FAIL mid_restart got=%0h/%0h exp=1/0", done, cpu_reset); end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    apply_reset();
    do_start(12'h080);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'd5);
    drive(1'b1, 32'd7);
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL ck_hold got=%0h exp=1", cpu_reset); end
    drive(1'b1, 32'd14);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL ck_pass got=%0h/%0h exp=1/0", done, error); end
    total++; if (cpu_reset !== 1'b0) begin bad++; $display("FAIL ck_pass_cpu got=%0h exp=0", cpu_reset); end
    total++; if (w_addr.size() != 2) begin bad++; $display("FAIL ck_nwrites got=%0d exp=2", w_addr.size()); end
    apply_reset();
    do_start(12'h080);
    drive(1'b1, 32'd2);
    drive(1'b1, 32'd5);
    drive(1'b1, 32'd7);
    drive(1'b1, 32'd15);
    drive(1'b0, 32'h0);
    drive(1'b0, 32'h0);
    total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ck_bad got=%0h/%0h exp=1/0", error, done); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL ck_bad_cpu got=%0h exp=1", cpu_reset); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef PROG_LOADER_CHECKSUM_EN
    test_basic();
    test_zero_header();
    test_stall();
    test_wrap();
`else
    test_checksum();
`endif
    test_error();
`ifndef PROG_LOADER_CHECKSUM_EN
    test_midload_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
